// File: rtl/seg_digit_mux_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the multiplexed 7-segment display driver:
//   - FSM state encoding (enum for debug views, plus localparam constants
//     used by the RTL state register)
//   - SEG_OFF, the all-segments-dark pattern
//   - HEX_SEG_TABLE, hex nibble -> active-low {g,f,e,d,c,b,a} pattern
// ---------------------------------------------------------------------------
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHOW  = 2'd1;
    localparam logic [1:0] ST_BLANK = 2'd2;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Entry [n] is the pattern for nibble n; listed from F down to 0.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/seg_digit_mux_hex_to_seg.sv
// ---------------------------------------------------------------------------
// hex_to_seg
// Combinational hex nibble to active-low 7-segment pattern.
// Ports:
//   nibble_i  [3:0]  hex digit to display
//   seg_o     [6:0]  {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG_TABLE[nibble_i];

endmodule

// File: rtl/seg_digit_mux.sv
// ---------------------------------------------------------------------------
// seg_digit_mux
// Drives an N-digit common-anode 7-segment display. Each level change of
// sel_toggle advances to the next digit, with an optional all-dark blanking
// interval in between to prevent ghosting. The displayed value is latched
// once per frame (when the digit index wraps to 0), so a frame never tears.
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   sel_toggle  digit-advance request (each level change = one request)
//   value       hex nibbles, digit 0 = value[3:0]
//   dp_in       per-digit decimal-point request, active-high
//   an          anode enables, active-low, registered
//   seg         segments {g,f,e,d,c,b,a}, active-low, registered
//   dp          decimal point, active-low, registered
//   digit_idx   digit currently shown (or next to be shown), registered
//   state_dbg   current FSM state (IDLE/SHOW/BLANK) for debug/checkers
//
// Build option: define SEG_LEADING_ZERO_BLANK_EN to dark leading-zero digits
// (digit 0 is always shown; anodes and timing are unaffected).
// ---------------------------------------------------------------------------
module seg_digit_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYCLES = 16,
    parameter int IDX_W        = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sel_toggle,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [IDX_W-1:0]        digit_idx,
    output logic [1:0]              state_dbg
);

    localparam int CNT_W = (BLANK_CYCLES > 2) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [1:0]              state_q, state_d;
    logic                    sel_q;
    logic [4*NUM_DIGITS-1:0] frame_val_q, frame_val_d;
    logic [NUM_DIGITS-1:0]   frame_dp_q, frame_dp_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d, idx_next;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;

    logic                    evt;
    logic                    advance;
    logic                    show_d;
    logic [3:0]              nib_d;
    logic [6:0]              dec_seg;
    logic                    lz_blank;

    // Request protocol: there is no valid/ready pair. sel_toggle is a level
    // that the producer flips once per request; a request is seen in the
    // cycle where it differs from its registered copy. Requests are only
    // honoured in SHOW; anything arriving in IDLE or BLANK is dropped, and
    // since sel_q keeps tracking, a dropped request never fires later.
    assign evt      = sel_toggle ^ sel_q;
    assign idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

    always_comb begin
        state_d     = state_q;
        frame_val_d = frame_val_q;
        frame_dp_d  = frame_dp_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        advance     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                frame_val_d = value;
                frame_dp_d  = dp_in;
                idx_d       = '0;
                state_d     = ST_SHOW;
            end
            ST_SHOW: begin
                if (evt) begin
                    if (BLANK_CYCLES > 0) begin
                        cnt_d   = CNT_LOAD;
                        state_d = ST_BLANK;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_BLANK: begin
                if (cnt_q == '0) begin
                    advance = 1'b1;
                    state_d = ST_SHOW;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Wrapping to digit 0 starts a new frame: capture the inputs now so
        // the whole frame shows one consistent snapshot.
        if (advance) begin
            idx_d = idx_next;
            if (idx_next == '0) begin
                frame_val_d = value;
                frame_dp_d  = dp_in;
            end
        end
    end

    // Outputs are registered from the next-state view, so the new digit (or
    // dark display) appears on the same edge that changes state.
    assign show_d = (state_d == ST_SHOW);
    assign nib_d  = frame_val_d[{idx_d, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .nibble_i (nib_d),
        .seg_o    (dec_seg)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Digit k > 0 is a leading zero when it and every higher nibble are 0.
    assign lz_blank = (idx_d != '0) && ((frame_val_d >> {idx_d, 2'b00}) == '0);
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        an_d = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            an_d[k] = !(show_d && (idx_d == IDX_W'(k)));
        end
        seg_d = (show_d && !lz_blank) ? dec_seg : SEG_OFF;
        dp_d  = show_d ? ~frame_dp_d[idx_d] : 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= 1'b0;
            frame_val_q <= '0;
            frame_dp_q  <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            an_q        <= '1;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_toggle;
            frame_val_q <= frame_val_d;
            frame_dp_q  <= frame_dp_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign digit_idx = idx_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_seg_digit_mux.sv
// ---------------------------------------------------------------------------
// tb_seg_digit_mux
// Two instances: dut_a (BLANK_CYCLES=16) and dut_b (BLANK_CYCLES=0).
// Stimulus pushes {due cycle, instance, an, seg, dp, idx} into exp_q; a
// negedge monitor pops entries when they fall due and compares.
// ---------------------------------------------------------------------------
module tb_seg_digit_mux;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ_SEG = 7'h7F;
`else
    localparam logic [6:0] LZ_SEG = 7'h40;
`endif

    // ---------------- DUTs ----------------
    logic        sel_a, sel_b;
    logic [15:0] val_a, val_b;
    logic [3:0]  dpi_a, dpi_b;
    logic [3:0]  an_a, an_b;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [1:0]  idx_a, idx_b;
    logic [1:0]  st_a, st_b;

    seg_digit_mux #(.NUM_DIGITS(4), .BLANK_CYCLES(16), .IDX_W(2)) dut_a (
        .clk(clk), .rst(rst), .sel_toggle(sel_a), .value(val_a), .dp_in(dpi_a),
        .an(an_a), .seg(seg_a), .dp(dp_a), .digit_idx(idx_a), .state_dbg(st_a)
    );

    seg_digit_mux #(.NUM_DIGITS(4), .BLANK_CYCLES(0), .IDX_W(2)) dut_b (
        .clk(clk), .rst(rst), .sel_toggle(sel_b), .value(val_b), .dp_in(dpi_b),
        .an(an_b), .seg(seg_b), .dp(dp_b), .digit_idx(idx_b), .state_dbg(st_b)
    );

    // ---------------- scoreboard ----------------
    // [46:15] due cycle, [14] instance, [13:10] an, [9:3] seg, [2] dp, [1:0] idx
    logic [46:0] exp_q[$];
    logic [46:0] e;
    logic [13:0] act;
    int tests  = 0;
    int fails  = 0;
    int nb_off = 0;
    logic mon_b_en = 1'b0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int d, input logic inst, input logic [3:0] an_e,
                             input logic [6:0] seg_e, input logic dp_e,
                             input logic [1:0] idx_e);
        exp_q.push_back({32'(cyc + d), inst, an_e, seg_e, dp_e, idx_e});
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && int'(exp_q[0][46:15]) <= cyc) begin
            e   = exp_q.pop_front();
            act = e[14] ? {an_b, seg_b, dp_b, idx_b} : {an_a, seg_a, dp_a, idx_a};
            tests++;
            if (int'(e[46:15]) < cyc) begin
                fails++;
                $display("FAIL late_check cyc=%0d due=%0d", cyc, int'(e[46:15]));
            end else if (act != e[13:0]) begin
                fails++;
                $display("FAIL out_dut%s cyc=%0d got an=%b seg=%h dp=%b idx=%0d want an=%b seg=%h dp=%b idx=%0d",
                         e[14] ? "b" : "a", cyc, act[13:10], act[9:3], act[2], act[1:0],
                         e[13:10], e[9:3], e[2], e[1:0]);
            end
        end
    end

    // With no blanking the display must never go fully dark between digits.
    always @(negedge clk) begin
        if (mon_b_en && an_b == 4'hF) nb_off++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst   = 1'b1;
        sel_a = 1'b0;
        sel_b = 1'b0;
        val_a = 16'h12A4;
        dpi_a = 4'b0010;
        val_b = 16'h0030;
        dpi_b = 4'b0000;
        tick(3);

        // reset values, then first digit one edge after release
        expect_at(0, 1'b0, 4'hF, 7'h7F, 1'b1, 2'd0);
        expect_at(0, 1'b1, 4'hF, 7'h7F, 1'b1, 2'd0);
        rst = 1'b0;
        expect_at(1,  1'b0, 4'b1110, 7'h19, 1'b1, 2'd0);
        expect_at(1,  1'b1, 4'b1110, 7'h40, 1'b1, 2'd0);
        expect_at(50, 1'b0, 4'b1110, 7'h19, 1'b1, 2'd0);
        tick(2);
        mon_b_en = 1'b1;
        tick(58);

        // dut_a: dark at t+1, still dark at t+16, digit 1 ('A', dp on) at t+17
        sel_a = 1'b1;
        expect_at(1,  1'b0, 4'hF,    7'h7F, 1'b1, 2'd0);
        expect_at(16, 1'b0, 4'hF,    7'h7F, 1'b1, 2'd0);
        expect_at(17, 1'b0, 4'b1101, 7'h08, 1'b0, 2'd1);
        tick(100);

        sel_a = 1'b0;
        expect_at(17, 1'b0, 4'b1011, 7'h24, 1'b1, 2'd2);
        tick(20);
        val_a = 16'h0007;           // mid-frame change, invisible until wrap
        tick(80);

        sel_a = 1'b1;
        expect_at(17, 1'b0, 4'b0111, 7'h79, 1'b1, 2'd3);
        tick(100);

        sel_a = 1'b0;
        expect_at(17, 1'b0, 4'b1110, 7'h78, 1'b1, 2'd0);
        tick(100);

        // second toggle inside BLANK is dropped
        sel_a = 1'b1;
        expect_at(1, 1'b0, 4'hF, 7'h7F, 1'b1, 2'd0);
        tick(5);
        sel_a = 1'b0;
        expect_at(11, 1'b0, 4'hF,    7'h7F,  1'b1, 2'd0);
        expect_at(12, 1'b0, 4'b1101, LZ_SEG, 1'b0, 2'd1);
        expect_at(13, 1'b0, 4'b1101, LZ_SEG, 1'b0, 2'd1);
        expect_at(35, 1'b0, 4'b1101, LZ_SEG, 1'b0, 2'd1);
        tick(60);

        // dut_b: no blanking, new digit one edge after the toggle
        sel_b = 1'b1;
        expect_at(1, 1'b1, 4'b1101, 7'h30, 1'b1, 2'd1);
        tick(10);
        sel_b = 1'b0;
        expect_at(1, 1'b1, 4'b1011, LZ_SEG, 1'b1, 2'd2);
        tick(10);
        sel_b = 1'b1;
        expect_at(1, 1'b1, 4'b0111, LZ_SEG, 1'b1, 2'd3);
        tick(10);
        sel_b = 1'b0;
        expect_at(1, 1'b1, 4'b1110, 7'h40, 1'b1, 2'd0);
        tick(10);
        mon_b_en = 1'b0;

        // reset in the middle of dut_a's blanking interval
        sel_a = 1'b1;
        expect_at(1, 1'b0, 4'hF, 7'h7F, 1'b1, 2'd1);
        tick(5);
        rst = 1'b1;
        expect_at(0, 1'b0, 4'hF, 7'h7F, 1'b1, 2'd0);
        expect_at(0, 1'b1, 4'hF, 7'h7F, 1'b1, 2'd0);
        tick(3);
        rst = 1'b0;
        expect_at(1, 1'b0, 4'b1110, 7'h78, 1'b1, 2'd0);
        expect_at(1, 1'b1, 4'b1110, 7'h40, 1'b1, 2'd0);
        tick(5);

        // ---------------- final report ----------------
        tests++;
        if (nb_off != 0) begin
            fails++;
            $display("FAIL no_blank_dark got %0d dark cycles want 0", nb_off);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_checks got %0d left want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
